// File: rtl/fpnew_shared_apu_wrapper_pkg.sv
// Shared definitions for the APU-to-FPnew sharing wrapper: default sizes and the
// channel-field width helper used to build {channel, id} core tags.
package fpnew_shared_apu_wrapper_pkg;

    localparam int NB_CH_DEF           = 4;
    localparam int ID_WIDTH_DEF        = 9;
    localparam int NB_ARGS_DEF         = 3;
    localparam int DATA_WIDTH_DEF      = 32;
    localparam int OPCODE_WIDTH_DEF    = 6;
    localparam int FLAGS_IN_WIDTH_DEF  = 15;
    localparam int FLAGS_OUT_WIDTH_DEF = 5;
    localparam int RESP_DEPTH_DEF      = 2;
    localparam int FCNT_WIDTH_DEF      = 16;

    // A single channel still carries a 1-bit channel field in the tag.
    function automatic int ch_bits(input int nb_ch);
        return (nb_ch > 1) ? $clog2(nb_ch) : 1;
    endfunction

endpackage

// File: rtl/fpnew_shared_apu_wrapper_resp_fifo.sv
// Per-channel response FIFO; head data reads as zero while empty.
module fpnew_shared_apu_wrapper_resp_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/fpnew_shared_apu_wrapper.sv
// Shares one FPnew core among NB_CH APU ports: round-robin issue with per-channel
// credits, {channel, id} tagging, buffered responses and a saturating fault counter.
module fpnew_shared_apu_wrapper
    import fpnew_shared_apu_wrapper_pkg::*;
#(
    parameter int NB_CH           = NB_CH_DEF,
    parameter int ID_WIDTH        = ID_WIDTH_DEF,
    parameter int NB_ARGS         = NB_ARGS_DEF,
    parameter int DATA_WIDTH      = DATA_WIDTH_DEF,
    parameter int OPCODE_WIDTH    = OPCODE_WIDTH_DEF,
    parameter int FLAGS_IN_WIDTH  = FLAGS_IN_WIDTH_DEF,
    parameter int FLAGS_OUT_WIDTH = FLAGS_OUT_WIDTH_DEF,
    parameter int RESP_DEPTH      = RESP_DEPTH_DEF,
    parameter int FCNT_WIDTH      = FCNT_WIDTH_DEF,
    localparam int CH_BITS        = ch_bits(NB_CH)
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic [NB_CH-1:0]                           apu_req_i,
    output logic [NB_CH-1:0]                           apu_gnt_o,
    input  logic [NB_CH-1:0][ID_WIDTH-1:0]             apu_ID_i,
    input  logic [NB_CH-1:0][NB_ARGS-1:0][DATA_WIDTH-1:0] apu_operands_i,
    input  logic [NB_CH-1:0][OPCODE_WIDTH-1:0]         apu_op_i,
    input  logic [NB_CH-1:0][FLAGS_IN_WIDTH-1:0]       apu_flags_i,
    input  logic [NB_CH-1:0]                           apu_rready_i,
    output logic [NB_CH-1:0]                           apu_rvalid_o,
    output logic [NB_CH-1:0][DATA_WIDTH-1:0]           apu_rdata_o,
    output logic [NB_CH-1:0][FLAGS_OUT_WIDTH-1:0]      apu_rflags_o,
    output logic [NB_CH-1:0][ID_WIDTH-1:0]             apu_rID_o,
    output logic                                       fpu_req_o,
    input  logic                                       fpu_gnt_i,
    output logic [CH_BITS+ID_WIDTH-1:0]                fpu_tag_o,
    output logic [NB_ARGS-1:0][DATA_WIDTH-1:0]         fpu_operands_o,
    output logic [OPCODE_WIDTH-1:0]                    fpu_op_o,
    output logic [FLAGS_IN_WIDTH-1:0]                  fpu_flags_o,
    input  logic                                       fpu_rvalid_i,
    input  logic [DATA_WIDTH-1:0]                      fpu_rdata_i,
    input  logic [FLAGS_OUT_WIDTH-1:0]                 fpu_rflags_i,
    input  logic [CH_BITS+ID_WIDTH-1:0]                fpu_rtag_i,
    input  logic                                       fpu_fault_i,
    input  logic                                       fault_clear_i,
    output logic [FCNT_WIDTH-1:0]                      fault_count_o,
    output logic                                       tag_err_o
);
    localparam int CNT_W = $clog2(RESP_DEPTH + 1);

    typedef struct packed {
        logic [CH_BITS-1:0]  ch;
        logic [ID_WIDTH-1:0] id;
    } chan_tag_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]      rdata;
        logic [FLAGS_OUT_WIDTH-1:0] rflags;
        logic [ID_WIDTH-1:0]        id;
    } resp_entry_t;

    localparam int ENTRY_W = $bits(resp_entry_t);

    logic [CH_BITS-1:0] rr_ptr, sel;
    logic [NB_CH-1:0]   eligible, pop, push, fifo_empty, fifo_full;
    logic [CNT_W-1:0]   cnt [NB_CH];
    resp_entry_t        fifo_rdata [NB_CH];
    resp_entry_t        wentry;
    chan_tag_t          rtag;
    logic               rtag_valid, issue;

    always_comb begin
        for (int c = 0; c < NB_CH; c++)
            eligible[c] = apu_req_i[c] & (cnt[c] < CNT_W'(RESP_DEPTH));
    end

    // Walk downward so the channel closest to rr_ptr is the last (winning) match.
    always_comb begin : arbiter
        logic [CH_BITS:0] idx;
        idx = '0;
        sel = '0;
        for (int i = NB_CH - 1; i >= 0; i--) begin
            idx = {1'b0, rr_ptr} + (CH_BITS + 1)'(i);
            if (idx >= (CH_BITS + 1)'(NB_CH)) idx = idx - (CH_BITS + 1)'(NB_CH);
            if (eligible[idx[CH_BITS-1:0]]) sel = idx[CH_BITS-1:0];
        end
    end

    assign fpu_req_o      = |eligible;
    assign issue          = fpu_req_o & fpu_gnt_i;
    assign fpu_tag_o      = chan_tag_t'{ch: sel, id: apu_ID_i[sel]};
    assign fpu_operands_o = apu_operands_i[sel];
    assign fpu_op_o       = apu_op_i[sel];
    assign fpu_flags_o    = apu_flags_i[sel];

    assign rtag       = chan_tag_t'(fpu_rtag_i);
    assign rtag_valid = int'(rtag.ch) < NB_CH;
    assign wentry     = resp_entry_t'{rdata: fpu_rdata_i, rflags: fpu_rflags_i, id: rtag.id};

    always_comb begin
        for (int c = 0; c < NB_CH; c++) begin
            apu_gnt_o[c]    = issue & (sel == CH_BITS'(c));
            push[c]         = fpu_rvalid_i & rtag_valid & (rtag.ch == CH_BITS'(c));
            pop[c]          = ~fifo_empty[c] & apu_rready_i[c];
            apu_rvalid_o[c] = ~fifo_empty[c];
            apu_rdata_o[c]  = fifo_rdata[c].rdata;
            apu_rflags_o[c] = fifo_rdata[c].rflags;
            apu_rID_o[c]    = fifo_rdata[c].id;
        end
    end

    for (genvar c = 0; c < NB_CH; c++) begin : g_resp
        fpnew_shared_apu_wrapper_resp_fifo #(
            .DEPTH (RESP_DEPTH),
            .WIDTH (ENTRY_W)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push[c] & (~fifo_full[c] | pop[c])),
            .wdata (wentry),
            .pop   (pop[c]),
            .rdata (fifo_rdata[c]),
            .empty (fifo_empty[c]),
            .full  (fifo_full[c])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr        <= '0;
            fault_count_o <= '0;
            tag_err_o     <= 1'b0;
            for (int c = 0; c < NB_CH; c++) cnt[c] <= '0;
        end else begin
            if (issue) rr_ptr <= (sel == CH_BITS'(NB_CH - 1)) ? '0 : sel + 1'b1;
            if (fpu_rvalid_i && !rtag_valid) tag_err_o <= 1'b1;
            if (fault_clear_i) fault_count_o <= '0;
            else if (fpu_fault_i && (fault_count_o != '1)) fault_count_o <= fault_count_o + 1'b1;
            for (int c = 0; c < NB_CH; c++) begin
                if (apu_gnt_o[c] && !pop[c])      cnt[c] <= cnt[c] + 1'b1;
                else if (!apu_gnt_o[c] && pop[c]) cnt[c] <= cnt[c] - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fpnew_shared_apu_wrapper.sv
// Directed bench: a 4-channel wrapper for arbitration/credits/responses, plus a
// 3-channel, 4-bit fault-count wrapper for tag errors and counter saturation.
module tb_fpnew_shared_apu_wrapper;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0]              req, gnt, rready, rvalid;
    logic [3:0][8:0]         id, rid;
    logic [3:0][2:0][31:0]   operands;
    logic [3:0][5:0]         op;
    logic [3:0][14:0]        flags;
    logic [3:0][31:0]        rdata;
    logic [3:0][4:0]         rflags;
    logic                    fpu_req, fpu_gnt, fpu_rvalid, tag_err;
    logic [10:0]             fpu_tag, fpu_rtag;
    logic [2:0][31:0]        fpu_operands;
    logic [5:0]              fpu_op;
    logic [14:0]             fpu_flags;
    logic [31:0]             fpu_rdata;
    logic [4:0]              fpu_rflags;
    logic                    fpu_fault, fault_clear;
    logic [15:0]             fault_count;

    logic [2:0]              d3_req, d3_gnt, d3_rready, d3_rvalid;
    logic [2:0][8:0]         d3_id, d3_rid;
    logic [2:0][2:0][31:0]   d3_operands;
    logic [2:0][5:0]         d3_op;
    logic [2:0][14:0]        d3_flags;
    logic [2:0][31:0]        d3_rdata;
    logic [2:0][4:0]         d3_rflags;
    logic                    d3_fpu_req, d3_fpu_rvalid, d3_tag_err;
    logic [10:0]             d3_fpu_tag, d3_fpu_rtag;
    logic [2:0][31:0]        d3_fpu_operands;
    logic [5:0]              d3_fpu_op;
    logic [14:0]             d3_fpu_flags;
    logic [3:0]              d3_fault_count;

    fpnew_shared_apu_wrapper u_dut (
        .clk(clk), .rst_n(rst_n),
        .apu_req_i(req), .apu_gnt_o(gnt), .apu_ID_i(id), .apu_operands_i(operands),
        .apu_op_i(op), .apu_flags_i(flags), .apu_rready_i(rready), .apu_rvalid_o(rvalid),
        .apu_rdata_o(rdata), .apu_rflags_o(rflags), .apu_rID_o(rid),
        .fpu_req_o(fpu_req), .fpu_gnt_i(fpu_gnt), .fpu_tag_o(fpu_tag),
        .fpu_operands_o(fpu_operands), .fpu_op_o(fpu_op), .fpu_flags_o(fpu_flags),
        .fpu_rvalid_i(fpu_rvalid), .fpu_rdata_i(fpu_rdata), .fpu_rflags_i(fpu_rflags),
        .fpu_rtag_i(fpu_rtag), .fpu_fault_i(fpu_fault), .fault_clear_i(fault_clear),
        .fault_count_o(fault_count), .tag_err_o(tag_err)
    );

    fpnew_shared_apu_wrapper #(.NB_CH(3), .FCNT_WIDTH(4)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .apu_req_i(d3_req), .apu_gnt_o(d3_gnt), .apu_ID_i(d3_id), .apu_operands_i(d3_operands),
        .apu_op_i(d3_op), .apu_flags_i(d3_flags), .apu_rready_i(d3_rready), .apu_rvalid_o(d3_rvalid),
        .apu_rdata_o(d3_rdata), .apu_rflags_o(d3_rflags), .apu_rID_o(d3_rid),
        .fpu_req_o(d3_fpu_req), .fpu_gnt_i(1'b1), .fpu_tag_o(d3_fpu_tag),
        .fpu_operands_o(d3_fpu_operands), .fpu_op_o(d3_fpu_op), .fpu_flags_o(d3_fpu_flags),
        .fpu_rvalid_i(d3_fpu_rvalid), .fpu_rdata_i(fpu_rdata), .fpu_rflags_i(fpu_rflags),
        .fpu_rtag_i(d3_fpu_rtag), .fpu_fault_i(fpu_fault), .fault_clear_i(fault_clear),
        .fault_count_o(d3_fault_count), .tag_err_o(d3_tag_err)
    );

    // Core-side stimulus: one response beat for channel ch carrying a data value derived from id.
    task automatic send_resp(input logic [1:0] ch, input logic [8:0] rid_v);
        fpu_rvalid = 1'b1;
        fpu_rtag   = {ch, rid_v};
        fpu_rdata  = 32'hA000_0000 | 32'(rid_v);
        fpu_rflags = rid_v[4:0];
        @(posedge clk); #1;
        fpu_rvalid = 1'b0;
    endtask

    task automatic test_reset;
        req = '0; id = '0; operands = '0; op = '0; flags = '0; rready = 4'hF;
        fpu_gnt = 1'b1; fpu_rvalid = 1'b0; fpu_rtag = '0; fpu_rdata = '0; fpu_rflags = '0;
        fpu_fault = 1'b0; fault_clear = 1'b0;
        d3_req = '0; d3_id = '0; d3_operands = '0; d3_op = '0; d3_flags = '0; d3_rready = 3'h7;
        d3_fpu_rvalid = 1'b0; d3_fpu_rtag = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        n_tests++; if (gnt !== 4'h0) begin n_fail++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
        n_tests++; if (fpu_req !== 1'b0) begin n_fail++; $display("FAIL reset_fpu_req: got %b expected 0", fpu_req); end
        n_tests++; if (rvalid !== 4'h0) begin n_fail++; $display("FAIL reset_rvalid: got %b expected 0000", rvalid); end
        n_tests++; if (rdata !== '0 || rid !== '0 || rflags !== '0) begin n_fail++; $display("FAIL reset_payload: got rdata %h rid %h expected 0", rdata, rid); end
        n_tests++; if (fault_count !== 16'd0) begin n_fail++; $display("FAIL reset_fcnt: got %0d expected 0", fault_count); end
        n_tests++; if (tag_err !== 1'b0 || d3_tag_err !== 1'b0) begin n_fail++; $display("FAIL reset_tag_err: got %b/%b expected 0/0", tag_err, d3_tag_err); end
        n_tests++; if (d3_rvalid !== 3'h0 || d3_fault_count !== 4'd0) begin n_fail++; $display("FAIL reset_d3: got rvalid %b fcnt %0d expected 0", d3_rvalid, d3_fault_count); end
        @(posedge clk); #1;
    endtask

    task automatic test_round_robin;
        int exp_ch;
        for (int c = 0; c < 4; c++) begin
            id[c] = 9'(10 + c);
            op[c] = 6'(c + 1);
            operands[c][0] = 32'h1000 + 32'(c);
        end
        req = 4'hF;
        for (int i = 0; i < 5; i++) begin
            exp_ch = i % 4;
            @(negedge clk);
            n_tests++; if (gnt !== 4'(1 << exp_ch)) begin n_fail++; $display("FAIL rr_gnt[%0d]: got %b expected %b", i, gnt, 4'(1 << exp_ch)); end
            n_tests++; if (fpu_tag !== {2'(exp_ch), 9'(10 + exp_ch)}) begin n_fail++; $display("FAIL rr_tag[%0d]: got %h expected %h", i, fpu_tag, {2'(exp_ch), 9'(10 + exp_ch)}); end
            n_tests++; if (fpu_op !== 6'(exp_ch + 1) || fpu_operands[0] !== 32'h1000 + 32'(exp_ch)) begin n_fail++; $display("FAIL rr_payload[%0d]: got op %0d opa %h expected op %0d", i, fpu_op, fpu_operands[0], exp_ch + 1); end
            @(posedge clk); #1;
        end
        req = '0;
        for (int i = 0; i < 5; i++) begin
            exp_ch = i % 4;
            send_resp(2'(exp_ch), 9'(10 + exp_ch));
            @(negedge clk);
            n_tests++; if (rvalid !== 4'(1 << exp_ch) || rid[exp_ch] !== 9'(10 + exp_ch) || rdata[exp_ch] !== (32'hA000_0000 | 32'(10 + exp_ch))) begin
                n_fail++; $display("FAIL rr_resp[%0d]: got rvalid %b rid %0d rdata %h expected ch %0d id %0d", i, rvalid, rid[exp_ch], rdata[exp_ch], exp_ch, 10 + exp_ch);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_credit_stall;
        rready[1] = 1'b0; id[1] = 9'd21; req = 4'b0010;
        @(negedge clk);
        n_tests++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL credit_gnt1: got %b expected 0010", gnt); end
        @(posedge clk); #1; id[1] = 9'd22;
        @(negedge clk);
        n_tests++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL credit_gnt2: got %b expected 0010", gnt); end
        @(posedge clk); #1; id[1] = 9'd23;
        @(negedge clk);
        n_tests++; if (gnt !== 4'b0000 || fpu_req !== 1'b0) begin n_fail++; $display("FAIL credit_stall: got gnt %b req %b expected 0000/0", gnt, fpu_req); end
        send_resp(2'd1, 9'd21);
        @(negedge clk);
        n_tests++; if (rvalid[1] !== 1'b1 || gnt !== 4'b0000) begin n_fail++; $display("FAIL credit_unpopped: got rvalid %b gnt %b expected 1/0000", rvalid[1], gnt); end
        @(posedge clk); #1; rready[1] = 1'b1;
        @(negedge clk);
        n_tests++; if (gnt !== 4'b0000 || rid[1] !== 9'd21) begin n_fail++; $display("FAIL credit_pop_cycle: got gnt %b rid %0d expected 0000/21", gnt, rid[1]); end
        @(posedge clk); #1;
        @(negedge clk);
        n_tests++; if (gnt !== 4'b0010 || fpu_tag !== {2'd1, 9'd23}) begin n_fail++; $display("FAIL credit_release: got gnt %b tag %h expected 0010/%h", gnt, fpu_tag, {2'd1, 9'd23}); end
        @(posedge clk); #1; req = '0;
        send_resp(2'd1, 9'd22);
        @(negedge clk);
        n_tests++; if (rid[1] !== 9'd22) begin n_fail++; $display("FAIL credit_drain1: got %0d expected 22", rid[1]); end
        send_resp(2'd1, 9'd23);
        @(negedge clk);
        n_tests++; if (rid[1] !== 9'd23) begin n_fail++; $display("FAIL credit_drain2: got %0d expected 23", rid[1]); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        id[2] = 9'd5; req = 4'b0100;
        @(negedge clk);
        n_tests++; if (gnt !== 4'b0100 || fpu_tag !== {2'd2, 9'd5}) begin n_fail++; $display("FAIL b2b_issue5: got gnt %b tag %h", gnt, fpu_tag); end
        @(posedge clk); #1; id[2] = 9'd6;
        @(negedge clk);
        n_tests++; if (gnt !== 4'b0100 || fpu_tag !== {2'd2, 9'd6}) begin n_fail++; $display("FAIL b2b_issue6: got gnt %b tag %h", gnt, fpu_tag); end
        @(posedge clk); #1; req = '0;
        fpu_rvalid = 1'b1; fpu_rtag = {2'd2, 9'd5}; fpu_rdata = 32'hA000_0005; fpu_rflags = 5'd5;
        @(negedge clk);
        n_tests++; if (rvalid[2] !== 1'b0) begin n_fail++; $display("FAIL b2b_latency: got rvalid %b expected 0 in core cycle", rvalid[2]); end
        @(posedge clk); #1;
        fpu_rtag = {2'd2, 9'd6}; fpu_rdata = 32'hA000_0006; fpu_rflags = 5'd6;
        @(negedge clk);
        n_tests++; if (rvalid[2] !== 1'b1 || rid[2] !== 9'd5 || rdata[2] !== 32'hA000_0005 || rflags[2] !== 5'd5) begin
            n_fail++; $display("FAIL b2b_first: got rvalid %b rid %0d rdata %h rflags %0d expected 1/5/a0000005/5", rvalid[2], rid[2], rdata[2], rflags[2]);
        end
        @(posedge clk); #1; fpu_rvalid = 1'b0;
        @(negedge clk);
        n_tests++; if (rvalid[2] !== 1'b1 || rid[2] !== 9'd6 || rdata[2] !== 32'hA000_0006) begin n_fail++; $display("FAIL b2b_second: got rvalid %b rid %0d rdata %h expected 1/6", rvalid[2], rid[2], rdata[2]); end
        @(posedge clk); #1;
        @(negedge clk);
        n_tests++; if (rvalid !== 4'h0) begin n_fail++; $display("FAIL b2b_empty: got %b expected 0000", rvalid); end
        @(posedge clk); #1;
    endtask

    task automatic test_full_push_pop;
        rready[0] = 1'b0; id[0] = 9'd31; req = 4'b0001;
        @(negedge clk);
        n_tests++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL full_issue31: got %b expected 0001", gnt); end
        @(posedge clk); #1; id[0] = 9'd32;
        @(negedge clk);
        n_tests++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL full_issue32: got %b expected 0001", gnt); end
        @(posedge clk); #1; req = '0;
        send_resp(2'd0, 9'd31);
        send_resp(2'd0, 9'd32);
        rready[0] = 1'b1; id[0] = 9'd33; req = 4'b0001;
        fpu_rvalid = 1'b1; fpu_rtag = {2'd0, 9'd33}; fpu_rdata = 32'hA000_0021; fpu_rflags = 5'd1;
        @(negedge clk);
        n_tests++; if (gnt !== 4'b0000 || rid[0] !== 9'd31 || rvalid[0] !== 1'b1) begin n_fail++; $display("FAIL full_pushpop: got gnt %b rid %0d rvalid %b expected 0000/31/1", gnt, rid[0], rvalid[0]); end
        @(posedge clk); #1; fpu_rvalid = 1'b0;
        @(negedge clk);
        n_tests++; if (rid[0] !== 9'd32 || gnt !== 4'b0001) begin n_fail++; $display("FAIL full_order32: got rid %0d gnt %b expected 32/0001", rid[0], gnt); end
        @(posedge clk); #1; req = '0;
        @(negedge clk);
        n_tests++; if (rid[0] !== 9'd33 || rvalid[0] !== 1'b1 || rdata[0] !== 32'hA000_0021) begin n_fail++; $display("FAIL full_order33: got rid %0d rvalid %b rdata %h expected 33/1/a0000021", rid[0], rvalid[0], rdata[0]); end
        @(posedge clk); #1;
        @(negedge clk);
        n_tests++; if (rvalid !== 4'h0) begin n_fail++; $display("FAIL full_empty: got %b expected 0000", rvalid); end
        @(posedge clk); #1;
    endtask

    task automatic test_fault_counter;
        fpu_fault = 1'b1;
        repeat (14) @(posedge clk);
        #1;
        @(negedge clk);
        n_tests++; if (d3_fault_count !== 4'd14 || fault_count !== 16'd14) begin n_fail++; $display("FAIL fault_14: got %0d/%0d expected 14/14", d3_fault_count, fault_count); end
        repeat (6) @(posedge clk);
        #1; fpu_fault = 1'b0;
        @(negedge clk);
        n_tests++; if (d3_fault_count !== 4'd15) begin n_fail++; $display("FAIL fault_sat: got %0d expected 15", d3_fault_count); end
        n_tests++; if (fault_count !== 16'd20) begin n_fail++; $display("FAIL fault_wide: got %0d expected 20", fault_count); end
        @(posedge clk); #1;
        fault_clear = 1'b1; fpu_fault = 1'b1;
        @(posedge clk); #1;
        fault_clear = 1'b0; fpu_fault = 1'b0;
        @(negedge clk);
        n_tests++; if (d3_fault_count !== 4'd0 || fault_count !== 16'd0) begin n_fail++; $display("FAIL fault_clear: got %0d/%0d expected 0/0", d3_fault_count, fault_count); end
        @(posedge clk); #1; fpu_fault = 1'b1;
        @(posedge clk); #1; fpu_fault = 1'b0;
        @(negedge clk);
        n_tests++; if (d3_fault_count !== 4'd1 || fault_count !== 16'd1) begin n_fail++; $display("FAIL fault_restart: got %0d/%0d expected 1/1", d3_fault_count, fault_count); end
        @(posedge clk); #1;
    endtask

    task automatic test_tag_err;
        d3_fpu_rvalid = 1'b1; d3_fpu_rtag = {2'd3, 9'd7};
        @(posedge clk); #1; d3_fpu_rvalid = 1'b0;
        @(negedge clk);
        n_tests++; if (d3_rvalid !== 3'h0) begin n_fail++; $display("FAIL tag_err_drop: got rvalid %b expected 000", d3_rvalid); end
        n_tests++; if (d3_tag_err !== 1'b1 || tag_err !== 1'b0) begin n_fail++; $display("FAIL tag_err_set: got %b/%b expected 1/0", d3_tag_err, tag_err); end
        @(posedge clk); #1;
        @(negedge clk);
        n_tests++; if (d3_tag_err !== 1'b1) begin n_fail++; $display("FAIL tag_err_sticky: got %b expected 1", d3_tag_err); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        rready[2] = 1'b0; id[2] = 9'd40; req = 4'b0100;
        @(posedge clk); #1; req = '0;
        send_resp(2'd2, 9'd40);
        @(negedge clk);
        n_tests++; if (rvalid[2] !== 1'b1 || rid[2] !== 9'd40) begin n_fail++; $display("FAIL rstmid_setup: got rvalid %b rid %0d expected 1/40", rvalid[2], rid[2]); end
        rst_n = 1'b0;
        #1;
        n_tests++; if (rvalid !== 4'h0 || rid !== '0 || rdata !== '0) begin n_fail++; $display("FAIL rstmid_resp: got rvalid %b rid %h expected 0", rvalid, rid); end
        n_tests++; if (fault_count !== 16'd0 || d3_fault_count !== 4'd0 || d3_tag_err !== 1'b0) begin n_fail++; $display("FAIL rstmid_state: got fcnt %0d/%0d tag_err %b expected 0", fault_count, d3_fault_count, d3_tag_err); end
        n_tests++; if (gnt !== 4'h0 || fpu_req !== 1'b0) begin n_fail++; $display("FAIL rstmid_req: got gnt %b req %b expected 0", gnt, fpu_req); end
        @(posedge clk); #1;
        rst_n = 1'b1; rready = 4'hF;
        req = 4'b1001; id[0] = 9'd50; id[3] = 9'd53;
        @(negedge clk);
        n_tests++; if (gnt !== 4'b0001 || fpu_tag !== {2'd0, 9'd50}) begin n_fail++; $display("FAIL rstmid_rr: got gnt %b tag %h expected 0001/%h", gnt, fpu_tag, {2'd0, 9'd50}); end
        @(posedge clk); #1; req = '0;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_credit_stall();
        test_back_to_back();
        test_full_push_pop();
        test_fault_counter();
        test_tag_err();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_tests);
        $fatal(1);
    end

endmodule
